key_trigger_debounce: RTL

- Upstream feeder of the staggered-delay reset sequencer.
- Takes a raw, bouncing push-button level, synchronises and debounces it, then emits a clean single-cycle trigger on each accepted press.
- Applies a lockout so that a new trigger cannot be issued while the downstream 100/200/300/400 ms sequence is still running.
- Rejected presses are flagged rather than silently dropped.

---
 rtl/key_trigger_pkg.sv | 15 +
 rtl/sync_2ff.sv | 23 ++
 rtl/key_trigger_debounce.sv | 139 +++++++++++++
 3 files changed

// File: rtl/key_trigger_pkg.sv
// rtl/key_trigger_pkg.sv - shared state encodings and default timing for the key trigger debouncer
package key_trigger_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    PRESS_DB = 2'd1,
    HELD     = 2'd2,
    REL_DB   = 2'd3
  } kt_state_t;

  localparam int CLK_HZ        = 50000000;
  localparam int DEBOUNCE_20MS = CLK_HZ / 50;
  localparam int LOCKOUT_450MS = (CLK_HZ / 1000) * 450;

endpackage

// File: rtl/sync_2ff.sv
// rtl/sync_2ff.sv - two-flop synchroniser with a configurable reset level
module sync_2ff #(
  parameter logic RESET_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk) begin
    if (rst) begin
      meta <= RESET_VAL;
      q    <= RESET_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/key_trigger_debounce.sv
// rtl/key_trigger_debounce.sv - push-button debounce with lockout-gated single-cycle trigger
// Optional power-on trigger one-shot enabled by KEY_TRIGGER_POR_TRIGGER_EN.
module key_trigger_debounce
  import key_trigger_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_20MS,
  parameter int LOCKOUT_CYCLES  = LOCKOUT_450MS,
  parameter int KEY_ACTIVE_LOW  = 1
) (
  input  logic iCLOCK50,
  input  logic iRESET,
  input  logic iKEY_RAW,
  output logic oTRIGGER,
  output logic oREJECT,
  output logic oKEY_STATE,
  output logic oBUSY
);

  localparam int DB_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int LK_W = $clog2(LOCKOUT_CYCLES + 1);
  localparam logic [DB_W-1:0] DB_LAST   = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [LK_W-1:0] LK_LOAD   = LK_W'(LOCKOUT_CYCLES);
  localparam logic            REL_LEVEL = (KEY_ACTIVE_LOW != 0);

  logic            key_sync;
  logic            pressed;
  kt_state_t       state, state_next;
  logic [DB_W-1:0] db_cnt, db_cnt_next;
  logic            press_done;
  logic [LK_W-1:0] lockout;
  logic            lock_idle;
  logic            por_fire;
  logic            fire;
  logic            reject;

  sync_2ff #(.RESET_VAL(REL_LEVEL)) u_key_sync (
    .clk(iCLOCK50),
    .rst(iRESET),
    .d  (iKEY_RAW),
    .q  (key_sync)
  );

  assign pressed = key_sync ^ REL_LEVEL;

  always_ff @(posedge iCLOCK50) begin
    if (iRESET) begin
      state  <= IDLE;
      db_cnt <= '0;
    end else begin
      state  <= state_next;
      db_cnt <= db_cnt_next;
    end
  end

  always_comb begin
    state_next  = state;
    db_cnt_next = db_cnt;
    press_done  = 1'b0;
    case (state)
      IDLE: begin
        db_cnt_next = '0;
        if (pressed) state_next = PRESS_DB;
      end
      PRESS_DB: begin
        if (!pressed) begin
          state_next  = IDLE;
          db_cnt_next = '0;
        end else if (db_cnt == DB_LAST) begin
          state_next  = HELD;
          db_cnt_next = '0;
          press_done  = 1'b1;
        end else begin
          db_cnt_next = db_cnt + DB_W'(1);
        end
      end
      HELD: begin
        db_cnt_next = '0;
        if (!pressed) state_next = REL_DB;
      end
      REL_DB: begin
        if (pressed) begin
          state_next  = HELD;
          db_cnt_next = '0;
        end else if (db_cnt == DB_LAST) begin
          state_next  = IDLE;
          db_cnt_next = '0;
        end else begin
          db_cnt_next = db_cnt + DB_W'(1);
        end
      end
      default: begin
        state_next  = IDLE;
        db_cnt_next = '0;
      end
    endcase
  end

`ifdef KEY_TRIGGER_POR_TRIGGER_EN
  logic [DB_W-1:0] por_cnt;
  logic            por_done;

  // One-shot: counts DEBOUNCE_CYCLES edges after reset, then stays spent until the next reset.
  always_ff @(posedge iCLOCK50) begin
    if (iRESET) begin
      por_cnt  <= '0;
      por_done <= 1'b0;
    end else if (!por_done) begin
      if (por_cnt == DB_LAST) por_done <= 1'b1;
      else                    por_cnt  <= por_cnt + DB_W'(1);
    end
  end

  assign por_fire = !por_done && (por_cnt == DB_LAST);
`else
  assign por_fire = 1'b0;
`endif

  assign lock_idle = (lockout == '0);
  assign fire      = por_fire || (press_done && lock_idle);
  assign reject    = press_done && !lock_idle && !por_fire;

  always_ff @(posedge iCLOCK50) begin
    if (iRESET) begin
      oTRIGGER   <= 1'b0;
      oREJECT    <= 1'b0;
      oKEY_STATE <= 1'b0;
      lockout    <= '0;
    end else begin
      oTRIGGER   <= fire;
      oREJECT    <= reject;
      oKEY_STATE <= (state_next == HELD) || (state_next == REL_DB);
      if (fire)            lockout <= LK_LOAD;
      else if (!lock_idle) lockout <= lockout - LK_W'(1);
    end
  end

  assign oBUSY = !lock_idle;

endmodule
